// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: widths, flag positions, mode and occupancy encodings.
package alu_pkg;

  localparam int ALU_W = 6;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic SEL_ADD = 1'b1;
  localparam logic SEL_SUB = 1'b0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/alu_flag_gen.sv
// Derives {N,Z,C,V} from an adder result and the operand sign bits.
// Latency: purely combinational.
// Backpressure: none, no state.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic [WIDTH-1:0] sum,
  input  logic             c_out,
  input  logic             x_msb,
  input  logic             y_msb,
  input  logic             sel,
  output logic [3:0]       flags
);

  logic s_msb;
  assign s_msb = sum[WIDTH-1];

  always_comb begin
    flags         = '0;
    flags[FLAG_N] = s_msb;
    flags[FLAG_Z] = (sum == '0);
    flags[FLAG_C] = c_out;
    // y_msb is the sign before negation, so subtract overflows on unlike signs
    if (sel == SEL_ADD) flags[FLAG_V] = (x_msb == y_msb) && (s_msb != x_msb);
    else                flags[FLAG_V] = (x_msb != y_msb) && (s_msb != x_msb);
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage: flags, 2-entry skid buffer, sticky overflow, delivery counter.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: in_ready is a flop, low only while both entries are occupied.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_c_out,
  input  logic             in_x_msb,
  input  logic             in_y_msb,
  input  logic             in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             sticky_v,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] res_count
);

  occ_e             state_q, state_d;
  logic [WIDTH-1:0] head_res_q, head_res_d, tail_res_q, tail_res_d;
  logic [3:0]       head_flg_q, head_flg_d, tail_flg_q, tail_flg_d;
  logic [3:0]       new_flags;
  logic             in_ready_q;
  logic             sticky_q;
  logic [CNT_W-1:0] cnt_q;
  logic             acc, del;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .sum   (in_sum),
    .c_out (in_c_out),
    .x_msb (in_x_msb),
    .y_msb (in_y_msb),
    .sel   (in_sel),
    .flags (new_flags)
  );

  assign acc = in_valid && in_ready_q;
  assign del = (state_q != EMPTY) && out_ready;

  always_comb begin
    state_d    = state_q;
    head_res_d = head_res_q;
    head_flg_d = head_flg_q;
    tail_res_d = tail_res_q;
    tail_flg_d = tail_flg_q;
    case (state_q)
      EMPTY: begin
        if (acc) begin
          head_res_d = in_sum;
          head_flg_d = new_flags;
          state_d    = ONE;
        end
      end
      ONE: begin
        case ({acc, del})
          2'b10: begin
            tail_res_d = in_sum;
            tail_flg_d = new_flags;
            state_d    = FULL;
          end
          2'b01: state_d = EMPTY;
          // head leaves as the new entry arrives, so it moves straight to the head
          2'b11: begin
            head_res_d = in_sum;
            head_flg_d = new_flags;
          end
          default: state_d = ONE;
        endcase
      end
      FULL: begin
        if (del) begin
          head_res_d = tail_res_q;
          head_flg_d = tail_flg_q;
          state_d    = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      head_res_q <= '0;
      head_flg_q <= '0;
      tail_res_q <= '0;
      tail_flg_q <= '0;
      in_ready_q <= 1'b1;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      head_res_q <= head_res_d;
      head_flg_q <= head_flg_d;
      tail_res_q <= tail_res_d;
      tail_flg_q <= tail_flg_d;
      in_ready_q <= (state_d != FULL);
      if (acc && new_flags[FLAG_V]) sticky_q <= 1'b1;
      else if (clr_sticky)          sticky_q <= 1'b0;
      if (del) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q != EMPTY);
  assign out_result = head_res_q;
  assign out_flags  = head_flg_q;
  assign sticky_v   = sticky_q;
  assign res_count  = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed vectors, queue of expected results, negedge monitor.
module tb_alu_result_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_sum;
  logic       in_c_out;
  logic       in_x_msb;
  logic       in_y_msb;
  logic       in_sel;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_result;
  logic [3:0] out_flags;
  logic       sticky_v;
  logic       clr_sticky;
  logic [7:0] res_count;

  logic [9:0] sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  alu_result_stage #(.WIDTH(6), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_c_out   (in_c_out),
    .in_x_msb   (in_x_msb),
    .in_y_msb   (in_y_msb),
    .in_sel     (in_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .sticky_v   (sticky_v),
    .clr_sticky (clr_sticky),
    .res_count  (res_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Delivery happens on the next rising edge; sample the handshake mid-cycle.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL deliver: got result=%0d flags=%b but no result was expected", out_result, out_flags);
      end else begin
        logic [9:0] exp_v;
        exp_v = sb.pop_front();
        if ({out_result, out_flags} !== exp_v) begin
          n_bad++;
          $display("FAIL deliver: got result=%0d flags=%b expected result=%0d flags=%b",
                   out_result, out_flags, exp_v[9:4], exp_v[3:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] s, input logic c, input logic x, input logic y,
                      input logic sel, input logic [3:0] exp_f);
    int waited;
    in_sum   = s;
    in_c_out = c;
    in_x_msb = x;
    in_y_msb = y;
    in_sel   = sel;
    in_valid = 1'b1;
    waited   = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!in_ready && waited < 50);
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready stayed 0 for sum=%0d", s);
    end else begin
      sb.push_back({s, exp_f});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_sum     = '0;
    in_c_out   = 1'b0;
    in_x_msb   = 1'b0;
    in_y_msb   = 1'b0;
    in_sel     = 1'b1;
    out_ready  = 1'b1;
    clr_sticky = 1'b0;
    repeat (2) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_flags", out_flags, 0);
    chk("rst_sticky", sticky_v, 0);
    chk("rst_count", res_count, 0);
    rst_n = 1'b1;
    tick();

    // 5+3: visible one cycle after accept
    send(6'b001000, 0, 0, 0, 1, 4'b0000);
    chk("lat_out_valid", out_valid, 1);
    chk("lat_out_result", out_result, 8);
    chk("lat_out_flags", out_flags, 4'b0000);
    tick();
    chk("empty_after_deliver", out_valid, 0);
    chk("hold_result", out_result, 8);
    chk("count_1", res_count, 1);

    // 31+1 overflow
    send(6'b100000, 0, 0, 0, 1, 4'b1001);
    chk("sticky_set", sticky_v, 1);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("sticky_clr", sticky_v, 0);

    send(6'b000000, 1, 0, 0, 0, 4'b0110);  // 3-3
    chk("sticky_no_v", sticky_v, 0);
    send(6'b100000, 0, 0, 1, 0, 4'b1001);  // 31-(-1)
    send(6'b111110, 1, 1, 1, 1, 4'b1010);  // -1+-1
    send(6'b000000, 1, 1, 1, 1, 4'b0111);  // -32+-32
    repeat (2) tick();
    chk("count_6", res_count, 6);
    chk("idle_out_valid", out_valid, 0);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;

    // backpressure: A,B fill the buffer, C is held off
    out_ready = 1'b0;
    send(6'd10, 0, 0, 0, 1, 4'b0000);
    send(6'd20, 0, 0, 0, 1, 4'b0000);
    chk("full_in_ready", in_ready, 0);
    chk("full_head", out_result, 10);
    fork
      send(6'd30, 0, 0, 0, 1, 4'b0000);
      begin
        repeat (3) tick();
        chk("stall_in_ready", in_ready, 0);
        chk("stall_head", out_result, 10);
        chk("stall_out_valid", out_valid, 1);
        chk("stall_count", res_count, 6);
        out_ready = 1'b1;
      end
    join
    repeat (3) tick();
    chk("count_9", res_count, 9);
    chk("drained", out_valid, 0);

    // ONE with accept and deliver together
    send(6'd1, 0, 0, 0, 1, 4'b0000);
    send(6'd2, 0, 0, 0, 1, 4'b0000);
    chk("one_keep_valid", out_valid, 1);
    chk("one_new_head", out_result, 2);
    chk("one_in_ready", in_ready, 1);
    tick();
    chk("one_to_empty", out_valid, 0);

    // V=1 accept coinciding with clr_sticky: set wins
    clr_sticky = 1'b1;
    send(6'b100000, 0, 0, 0, 1, 4'b1001);
    chk("sticky_set_wins", sticky_v, 1);
    clr_sticky = 1'b0;
    repeat (2) tick();
    chk("count_12", res_count, 12);

    // 256 deliveries bring the counter back to the same value
    for (int i = 0; i < 256; i++) begin
      logic [5:0] s;
      s = i[5:0];
      send(s, 0, 0, 0, 1, {s[5], (s == 6'd0), 1'b0, s[5]});
    end
    repeat (3) tick();
    chk("count_wrap", res_count, 12);

    // reset while FULL
    out_ready = 1'b0;
    send(6'b100000, 0, 0, 0, 1, 4'b1001);
    send(6'd5, 0, 0, 0, 1, 4'b0000);
    chk("pre_rst_in_ready", in_ready, 0);
    chk("pre_rst_sticky", sticky_v, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_result", out_result, 0);
    chk("mid_rst_flags", out_flags, 0);
    chk("mid_rst_sticky", sticky_v, 0);
    chk("mid_rst_count", res_count, 0);
    sb.delete();
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    send(6'd7, 0, 0, 0, 1, 4'b0000);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_result", out_result, 7);
    tick();
    chk("post_rst_count", res_count, 1);
    repeat (2) tick();
    chk("scoreboard_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
